// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the request/done handshake to a
// multi-cycle instruction memory, and loads the IF/ID register. A one-entry
// hold buffer absorbs stalls; redirects flush the wrong path, and a HALT from
// decode stops fetching until reset.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_in,
    input  logic        imem_done,
    input  logic [15:0] imem_rdata,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_inc,
    output logic        ifid_valid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD,
        HALTED
    } state_e;

    state_e      state_q,      state_d;
    logic [15:0] pc_q,         pc_d;
    logic [15:0] drop_addr_q,  drop_addr_d;
    logic [15:0] hold_q,       hold_d;
    logic [15:0] instr_q,      instr_d;
    logic [15:0] pc_inc_q,     pc_inc_d;
    logic        valid_q,      valid_d;
    logic        err_q,        err_d;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc_q + 16'd2;

    // Next-state: redirect beats halt beats stall beats normal flow.
    // In DISCARD, pc_q already holds the redirect target, so the still-pending
    // request is addressed from drop_addr_q until memory answers it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        hold_d      = hold_q;
        instr_d     = instr_q;
        pc_inc_d    = pc_inc_q;
        valid_d     = valid_q;
        err_d       = err_q;

        if (state_q != HALTED) begin
            if (redirect) begin
                instr_d  = NOP_INSTR;
                pc_inc_d = '0;
                valid_d  = 1'b0;
                hold_d   = '0;
                pc_d     = {redirect_pc[15:1], 1'b0};
                err_d    = err_q | redirect_pc[0];
                if (state_q != HOLD && !imem_done) begin
                    state_d = DISCARD;
                    if (state_q == FETCH) begin
                        drop_addr_d = pc_q;
                    end
                end else begin
                    state_d = FETCH;
                end
            end else if (halt_in) begin
                state_d  = HALTED;
                instr_d  = NOP_INSTR;
                pc_inc_d = '0;
                valid_d  = 1'b0;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (imem_done) begin
                            if (stall) begin
                                hold_d  = imem_rdata;
                                state_d = HOLD;
                            end else begin
                                instr_d  = imem_rdata;
                                pc_inc_d = pc_plus2;
                                valid_d  = 1'b1;
                                pc_d     = pc_plus2;
                            end
                        end else if (!stall) begin
                            instr_d  = NOP_INSTR;
                            pc_inc_d = '0;
                            valid_d  = 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            instr_d  = hold_q;
                            pc_inc_d = pc_plus2;
                            valid_d  = 1'b1;
                            pc_d     = pc_plus2;
                            state_d  = FETCH;
                        end
                    end
                    DISCARD: begin
                        instr_d  = NOP_INSTR;
                        pc_inc_d = '0;
                        valid_d  = 1'b0;
                        if (imem_done) begin
                            state_d = FETCH;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // State and pipeline register update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            hold_q      <= '0;
            instr_q     <= NOP_INSTR;
            pc_inc_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            hold_q      <= hold_d;
            instr_q     <= instr_d;
            pc_inc_q    <= pc_inc_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Memory request is gated by rst_n so it drops as soon as reset asserts.
    assign imem_req    = rst_n && (state_q == FETCH || state_q == DISCARD);
    assign imem_addr   = (state_q == DISCARD) ? drop_addr_q : pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc_inc = pc_inc_q;
    assign ifid_valid  = valid_q;
    assign halted      = (state_q == HALTED);
    assign err         = err_q;

endmodule
